// File: rtl/mem_bus_pkg.sv
// Shared definitions for the data-memory bus: default widths, arbiter state
// encoding and master indices.
package mem_bus_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  // One-hot mask of the master that owns the bus in a locked state.
  function automatic logic [1:0] lock_owner_mask(input arb_state_t s);
    logic [1:0] mask;
    mask = 2'b00;
    if (s == LOCK0) mask = 2'b01;
    if (s == LOCK1) mask = 2'b10;
    return mask;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select; a non-zero force mask restricts the grant to
// the forced master alone.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic [1:0] force_mask,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (force_mask != 2'b00) begin
      gnt = req & force_mask;
    end else if (req == 2'b11) begin
      gnt = rr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory, with
// bounded locked bursts and read-data return to the issuing master.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t        state, state_nxt;
  logic              rr, rr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              rd_pend;
  logic              rd_owner;

  logic [1:0]        pick;
  logic [1:0]        gnt;
  logic              beat;
  logic              who;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              owner;
  logic              owner_req;
  logic              owner_lock;

  rr_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .rr         (rr),
    .force_mask (lock_owner_mask(state)),
    .gnt        (pick)
  );

  // Grants are blanked while reset is held so no strobe can escape.
  always_comb begin
    gnt       = rst ? pick : 2'b00;
    beat      = |gnt;
    who       = gnt[1];
    sel_we    = who ? m1_we    : m0_we;
    sel_lock  = who ? m1_lock  : m0_lock;
    sel_addr  = who ? m1_addr  : m0_addr;
    sel_wdata = who ? m1_wdata : m0_wdata;
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign mem_read  = beat & ~sel_we;
  assign mem_write = beat & sel_we;
  assign mem_addr  = beat ? sel_addr : '0;
  assign mem_dout  = mem_write ? sel_wdata : '0;

  assign m0_rvalid = rst & rd_pend & (rd_owner == M_CPU);
  assign m1_rvalid = rst & rd_pend & (rd_owner == M_DMA);
  assign m0_rdata  = m0_rvalid ? mem_din : '0;
  assign m1_rdata  = m1_rvalid ? mem_din : '0;

  // cnt holds the number of beats already taken in the burst, so the beat
  // seen with cnt == MAX_BURST-1 is the last one the owner may take.
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr;
    cnt_nxt    = cnt;
    owner      = (state == LOCK1);
    owner_req  = owner ? m1_req  : m0_req;
    owner_lock = owner ? m1_lock : m0_lock;
    case (state)
      ARB: begin
        if (beat) begin
          if (sel_lock && (MAX_BURST > 1)) begin
            state_nxt = who ? LOCK1 : LOCK0;
            cnt_nxt   = CNT_W'(1);
          end else begin
            rr_nxt = ~who;
          end
        end
      end
      LOCK0, LOCK1: begin
        if (!owner_req || !owner_lock || (cnt == CNT_W'(MAX_BURST - 1))) begin
          state_nxt = ARB;
          rr_nxt    = ~owner;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ARB;
      rr       <= M_CPU;
      cnt      <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= M_CPU;
    end else begin
      state   <= state_nxt;
      rr      <= rr_nxt;
      cnt     <= cnt_nxt;
      rd_pend <= mem_read;
      if (mem_read) begin
        rd_owner <= who;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for single-cycle behaviour
// plus hand sequences for bursts, lock release and reset mid-burst.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] mem_din;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din)
  );

  typedef struct {
    logic       rst;
    logic       r0, w0, l0;
    logic [7:0] a0, d0;
    logic       r1, w1, l1;
    logic [7:0] a1, d1;
    logic [7:0] din;
    logic [1:0] gnt;
    logic       rd, wr;
    logic [7:0] addr, dout;
    logic [1:0] rv;
    logic [7:0] rdata0, rdata1;
  } vec_t;

  vec_t vecs[$];

  task automatic apply_stimulus(input logic r,
                                input logic r0, input logic w0, input logic l0,
                                input logic [7:0] a0, input logic [7:0] d0,
                                input logic r1, input logic w1, input logic l1,
                                input logic [7:0] a1, input logic [7:0] d1,
                                input logic [7:0] din);
    rst      = r;
    m0_req   = r0;
    m0_we    = w0;
    m0_lock  = l0;
    m0_addr  = a0;
    m0_wdata = d0;
    m1_req   = r1;
    m1_we    = w1;
    m1_lock  = l1;
    m1_addr  = a1;
    m1_wdata = d1;
    mem_din  = din;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Samples on the falling edge, then moves to just after the next rising edge.
  task automatic check_output(input string tag, input logic [1:0] gnt,
                              input logic rd, input logic wr,
                              input logic [7:0] addr, input logic [7:0] dout,
                              input logic [1:0] rv,
                              input logic [7:0] rdata0, input logic [7:0] rdata1);
    @(negedge clk);
    chk({tag, ".gnt"},    {6'd0, m1_gnt, m0_gnt},       {6'd0, gnt});
    chk({tag, ".rd"},     8'(mem_read),                 8'(rd));
    chk({tag, ".wr"},     8'(mem_write),                8'(wr));
    chk({tag, ".addr"},   mem_addr,                     addr);
    chk({tag, ".dout"},   mem_dout,                     dout);
    chk({tag, ".rvalid"}, {6'd0, m1_rvalid, m0_rvalid}, {6'd0, rv});
    chk({tag, ".rdata0"}, m0_rdata,                     rdata0);
    chk({tag, ".rdata1"}, m1_rdata,                     rdata1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00,
                   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // rst, m0{req,we,lock,addr,wdata}, m1{...}, din | gnt, rd, wr, addr, dout, rvalid, rdata0, rdata1
    vecs.push_back(vec_t'{1'b0, 1'b1,1'b0,1'b0,8'h10,8'h00, 1'b1,1'b0,1'b0,8'h10,8'h00, 8'h00,
                          2'b00, 1'b0,1'b0, 8'h00,8'h00, 2'b00, 8'h00,8'h00});
    vecs.push_back(vec_t'{1'b1, 1'b1,1'b0,1'b0,8'h10,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h00,
                          2'b01, 1'b1,1'b0, 8'h10,8'h00, 2'b00, 8'h00,8'h00});
    vecs.push_back(vec_t'{1'b1, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'hA5,
                          2'b00, 1'b0,1'b0, 8'h00,8'h00, 2'b01, 8'hA5,8'h00});
    vecs.push_back(vec_t'{1'b1, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,1'b0,8'h30,8'h11, 8'h00,
                          2'b10, 1'b0,1'b1, 8'h30,8'h11, 2'b00, 8'h00,8'h00});
    vecs.push_back(vec_t'{1'b1, 1'b1,1'b0,1'b0,8'h40,8'h00, 1'b1,1'b0,1'b0,8'h50,8'h00, 8'h00,
                          2'b01, 1'b1,1'b0, 8'h40,8'h00, 2'b00, 8'h00,8'h00});
    vecs.push_back(vec_t'{1'b1, 1'b1,1'b0,1'b0,8'h40,8'h00, 1'b1,1'b0,1'b0,8'h50,8'h00, 8'h77,
                          2'b10, 1'b1,1'b0, 8'h50,8'h00, 2'b01, 8'h77,8'h00});
    vecs.push_back(vec_t'{1'b1, 1'b1,1'b0,1'b0,8'h40,8'h00, 1'b1,1'b0,1'b0,8'h50,8'h00, 8'h88,
                          2'b01, 1'b1,1'b0, 8'h40,8'h00, 2'b10, 8'h00,8'h88});
    vecs.push_back(vec_t'{1'b1, 1'b1,1'b0,1'b0,8'h40,8'h00, 1'b1,1'b0,1'b0,8'h50,8'h00, 8'h99,
                          2'b10, 1'b1,1'b0, 8'h50,8'h00, 2'b01, 8'h99,8'h00});
    vecs.push_back(vec_t'{1'b1, 1'b1,1'b1,1'b0,8'h20,8'h3C, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'hAB,
                          2'b01, 1'b0,1'b1, 8'h20,8'h3C, 2'b10, 8'h00,8'hAB});
    vecs.push_back(vec_t'{1'b1, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h20,8'h00, 8'h00,
                          2'b10, 1'b1,1'b0, 8'h20,8'h00, 2'b00, 8'h00,8'h00});
    vecs.push_back(vec_t'{1'b1, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h3C,
                          2'b00, 1'b0,1'b0, 8'h00,8'h00, 2'b10, 8'h00,8'h3C});
    vecs.push_back(vec_t'{1'b1, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h55,
                          2'b00, 1'b0,1'b0, 8'h00,8'h00, 2'b00, 8'h00,8'h00});

    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].l0, vecs[i].a0, vecs[i].d0,
                     vecs[i].r1, vecs[i].w1, vecs[i].l1, vecs[i].a1, vecs[i].d1, vecs[i].din);
      check_output($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rd, vecs[i].wr,
                   vecs[i].addr, vecs[i].dout, vecs[i].rv, vecs[i].rdata0, vecs[i].rdata1);
    end

    // Locked burst by master 1 against a waiting master 0.
    apply_stimulus(1'b1, 1'b1,1'b0,1'b0,8'h01,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h00);
    check_output("burst.pre", 2'b01, 1'b1,1'b0, 8'h01,8'h00, 2'b00, 8'h00,8'h00);
    for (int i = 0; i < MB; i++) begin
      apply_stimulus(1'b1, 1'b1,1'b0,1'b0,8'h02,8'h00,
                     1'b1,1'b1,1'b1,8'h60 + 8'(i),8'hC0 + 8'(i), 8'h5A);
      check_output($sformatf("burst.beat%0d", i), 2'b10, 1'b0,1'b1, 8'h60 + 8'(i), 8'hC0 + 8'(i),
                   (i == 0) ? 2'b01 : 2'b00, (i == 0) ? 8'h5A : 8'h00, 8'h00);
    end
    apply_stimulus(1'b1, 1'b1,1'b0,1'b0,8'h02,8'h00, 1'b1,1'b1,1'b1,8'h64,8'hC4, 8'h00);
    check_output("burst.after", 2'b01, 1'b1,1'b0, 8'h02,8'h00, 2'b00, 8'h00,8'h00);
    apply_stimulus(1'b1, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h6B);
    check_output("burst.rv", 2'b00, 1'b0,1'b0, 8'h00,8'h00, 2'b01, 8'h6B,8'h00);

    // Locked owner drops its request; the other master waits one cycle.
    apply_stimulus(1'b1, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,8'h70,8'h00, 8'h00);
    check_output("drop.lock", 2'b10, 1'b1,1'b0, 8'h70,8'h00, 2'b00, 8'h00,8'h00);
    apply_stimulus(1'b1, 1'b1,1'b0,1'b0,8'h71,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'hE1);
    check_output("drop.idle", 2'b00, 1'b0,1'b0, 8'h00,8'h00, 2'b10, 8'h00,8'hE1);
    apply_stimulus(1'b1, 1'b1,1'b0,1'b0,8'h71,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h00);
    check_output("drop.other", 2'b01, 1'b1,1'b0, 8'h71,8'h00, 2'b00, 8'h00,8'h00);

    // Reset during the second beat of a locked burst.
    apply_stimulus(1'b1, 1'b1,1'b0,1'b1,8'h80,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h12);
    check_output("rstb.beat1", 2'b01, 1'b1,1'b0, 8'h80,8'h00, 2'b01, 8'h12,8'h00);
    apply_stimulus(1'b0, 1'b1,1'b0,1'b1,8'h81,8'h00, 1'b1,1'b0,1'b0,8'h90,8'h00, 8'h34);
    check_output("rstb.inrst", 2'b00, 1'b0,1'b0, 8'h00,8'h00, 2'b00, 8'h00,8'h00);
    apply_stimulus(1'b1, 1'b1,1'b0,1'b0,8'h82,8'h00, 1'b1,1'b0,1'b0,8'h91,8'h00, 8'h56);
    check_output("rstb.first", 2'b01, 1'b1,1'b0, 8'h82,8'h00, 2'b00, 8'h00,8'h00);
    apply_stimulus(1'b1, 1'b1,1'b0,1'b0,8'h82,8'h00, 1'b1,1'b0,1'b0,8'h91,8'h00, 8'h78);
    check_output("rstb.second", 2'b10, 1'b1,1'b0, 8'h91,8'h00, 2'b01, 8'h78,8'h00);
    apply_stimulus(1'b1, 1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h00,8'h00, 8'h9A);
    check_output("rstb.rv", 2'b00, 1'b0,1'b0, 8'h00,8'h00, 2'b10, 8'h00,8'h9A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
